irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl_pkg.sv | 18 +
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_ctrl.sv | 85 ++++++++
 tb/tb_irq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - irq_ctrl register map, control register layout and vector field positions
package irq_ctrl_pkg;

    localparam logic [4:0] IRQ_CR = 5'h00;
    localparam logic [4:0] IRQ_MR = 5'h04;
    localparam logic [4:0] IRQ_TR = 5'h08;
    localparam logic [4:0] IRQ_PR = 5'h0C;
    localparam logic [4:0] IRQ_VR = 5'h10;

    // Bit of IRQ_VR that flags a valid vector; the index sits in bits [4:0].
    localparam int IRQ_VR_VALID = 31;

    typedef struct packed {
        logic [30:0] rsvd;
        logic        gie;
    } irq_cr_v;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index-first priority encoder
module irq_prio_enc #(
    parameter int irq_n = 8
) (
    input  logic [irq_n-1:0] req,
    output logic             valid,
    output logic [4:0]       idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = 5'd0;
        for (int i = irq_n - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 5'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - maskable level/edge interrupt controller with pending latch and vector register
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int irq_n = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       addr,
    input  logic             we,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    input  logic [irq_n-1:0] irq_src,
    output logic             irq_out
);

    irq_cr_v          cr;
    logic [irq_n-1:0] mask;
    logic [irq_n-1:0] trig;
    logic [irq_n-1:0] pend;
    logic [irq_n-1:0] prev;

    logic             vr_valid;
    logic [4:0]       vr_idx;
    logic [irq_n-1:0] src_rise;
    logic [irq_n-1:0] pend_set;
    logic [irq_n-1:0] pend_clr;
    logic [irq_n-1:0] ack_mask;
    logic             wr_pr;
    logic             ack;

    irq_prio_enc #(.irq_n(irq_n)) u_prio_enc (
        .req   (pend & mask),
        .valid (vr_valid),
        .idx   (vr_idx)
    );

    assign src_rise = irq_src & ~prev;
    assign pend_set = (trig & src_rise) | (~trig & irq_src);
    assign wr_pr    = we && (addr == IRQ_PR);
    // An acknowledge only means something when there is a vector to retire.
    assign ack      = we && (addr == IRQ_VR) && vr_valid;
    assign ack_mask = irq_n'(1) << vr_idx;
    assign pend_clr = (wr_pr ? wd[irq_n-1:0] : '0) | (ack ? ack_mask : '0);

    // Upper write-data bits have no storage behind them.
    if (irq_n < 32) begin : g_unused_wd
        logic unused_wd;
        assign unused_wd = ^wd[31:irq_n];
    end

    // Register file, source history, pending latch and the merged interrupt flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cr      <= '0;
            mask    <= '0;
            trig    <= '0;
            pend    <= '0;
            prev    <= '0;
            irq_out <= 1'b0;
        end else begin
            if (we && (addr == IRQ_CR)) cr.gie <= wd[0];
            if (we && (addr == IRQ_MR)) mask   <= wd[irq_n-1:0];
            if (we && (addr == IRQ_TR)) trig   <= wd[irq_n-1:0];
            prev    <= irq_src;
            // A new request in the same cycle as a clear keeps the bit set.
            pend    <= pend_set | (pend & ~pend_clr);
            irq_out <= cr.gie & (|(pend & mask));
        end
    end

    // Read mux; unmapped addresses return zero.
    always_comb begin
        rd = '0;
        case (addr)
            IRQ_CR: rd = {31'd0, cr.gie};
            IRQ_MR: rd = 32'(mask);
            IRQ_TR: rd = 32'(trig);
            IRQ_PR: rd = 32'(pend);
            IRQ_VR: rd = vr_valid ? ((32'd1 << IRQ_VR_VALID) | 32'(vr_idx)) : 32'd0;
            default: rd = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard bench for irq_ctrl with directed vectors
module tb_irq_ctrl;

    localparam logic [4:0] A_CR = 5'h00;
    localparam logic [4:0] A_MR = 5'h04;
    localparam logic [4:0] A_TR = 5'h08;
    localparam logic [4:0] A_PR = 5'h0C;
    localparam logic [4:0] A_VR = 5'h10;

    logic        clk;
    logic        rstn;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  irq_src;
    logic        irq_out;

    irq_ctrl #(.irq_n(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .addr    (addr),
        .we      (we),
        .wd      (wd),
        .rd      (rd),
        .irq_src (irq_src),
        .irq_out (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_irq;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    bit   sample_req;
    int   checks;
    int   errors;

    // Monitor: on every sampled cycle, drain the expectations queued for it.
    always @(negedge clk) begin
        if (sample_req) begin
            while (sbq.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e   = sbq.pop_front();
                act = e.is_irq ? {31'd0, irq_out} : rd;
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic exp_rd(input string n, input logic [4:0] a, input logic [31:0] e);
        exp_t x;
        addr     = a;
        x.name   = n;
        x.is_irq = 1'b0;
        x.exp    = e;
        sbq.push_back(x);
    endtask

    task automatic exp_irq(input string n, input logic e);
        exp_t x;
        x.name   = n;
        x.is_irq = 1'b1;
        x.exp    = {31'd0, e};
        sbq.push_back(x);
    endtask

    // Hands the queued expectations to the monitor and advances one clock.
    task automatic sample();
        sample_req = 1'b1;
        @(negedge clk);
        #1;
        sample_req = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        sample_req = 1'b0;
        rstn       = 1'b0;
        addr       = '0;
        we         = 1'b0;
        wd         = '0;
        irq_src    = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Reset state.
        exp_rd("rst_cr", A_CR, 32'h0); exp_irq("rst_irq", 1'b0); sample();
        exp_rd("rst_mr", A_MR, 32'h0); sample();
        exp_rd("rst_tr", A_TR, 32'h0); sample();
        exp_rd("rst_pr", A_PR, 32'h0); sample();
        exp_rd("rst_vr", A_VR, 32'h0); sample();

        // Level source latches with gie off; irq_out stays low.
        irq_src[0] = 1'b1;
        tick();
        exp_rd("gie0_pr", A_PR, 32'h1); exp_irq("gie0_irq_a", 1'b0); sample();
        exp_irq("gie0_irq_b", 1'b0); sample();
        irq_src[0] = 1'b0;
        wr(A_PR, 32'h1);
        exp_rd("gie0_clr_pr", A_PR, 32'h0); sample();

        // Level mode, two-cycle latency from source to irq_out.
        wr(A_CR, 32'h1);
        wr(A_MR, 32'h1);
        wr(A_TR, 32'h0);
        irq_src[0] = 1'b1;
        tick();
        exp_irq("lvl_lat1", 1'b0); sample();
        exp_irq("lvl_lat2", 1'b1); sample();
        wr(A_PR, 32'h1);
        exp_rd("lvl_clr_held", A_PR, 32'h1); sample();
        irq_src[0] = 1'b0;
        wr(A_PR, 32'h1);
        exp_rd("lvl_clr_pr", A_PR, 32'h0); exp_irq("lvl_clr_irq_a", 1'b1); sample();
        exp_irq("lvl_clr_irq_b", 1'b0); sample();

        // Edge mode: long high pulse latches once; acknowledge via IRQ_VR.
        wr(A_TR, 32'h4);
        wr(A_MR, 32'h4);
        irq_src[2] = 1'b1;
        repeat (10) tick();
        exp_rd("edge_pr", A_PR, 32'h4); sample();
        exp_rd("edge_vr", A_VR, 32'h8000_0002); sample();
        exp_irq("edge_irq", 1'b1); sample();
        wr(A_VR, 32'h0);
        exp_rd("ack_pr", A_PR, 32'h0); exp_irq("ack_irq_a", 1'b1); sample();
        exp_rd("ack_vr", A_VR, 32'h0); exp_irq("ack_irq_b", 1'b0); sample();
        repeat (3) tick();
        exp_rd("edge_once", A_PR, 32'h0); sample();
        irq_src[2] = 1'b0;

        // Unimplemented bits are dropped.
        wr(A_MR, 32'hFFFF_FFFF);
        exp_rd("mr_width", A_MR, 32'h0000_00FF); sample();
        wr(A_TR, 32'hFFFF_FFFF);
        wr(A_CR, 32'hFFFF_FFFF);
        exp_rd("cr_width", A_CR, 32'h1); sample();

        // Two simultaneous edges: vector walks lowest index first.
        irq_src[3] = 1'b1;
        irq_src[5] = 1'b1;
        tick();
        exp_rd("prio_vr3", A_VR, 32'h8000_0003); sample();
        wr(A_VR, 32'h0);
        exp_rd("prio_vr5", A_VR, 32'h8000_0005); sample();
        wr(A_VR, 32'h0);
        exp_rd("prio_vr0", A_VR, 32'h0); sample();
        irq_src[3] = 1'b0;
        irq_src[5] = 1'b0;

        // Unmapped addresses.
        wr(5'h14, 32'hFFFF_FFFF);
        exp_rd("unmap_14", 5'h14, 32'h0); sample();
        exp_rd("unmap_1c", 5'h1C, 32'h0); sample();
        exp_rd("unmap_pr", A_PR, 32'h0); sample();

        // Edge and W1C in the same cycle: set wins.
        irq_src[1] = 1'b1;
        wr(A_PR, 32'h2);
        exp_rd("set_wins_pr", A_PR, 32'h2); sample();
        exp_rd("set_wins_pr2", A_PR, 32'h2); exp_irq("set_wins_irq", 1'b1); sample();

        // Asynchronous reset mid-pending, checked before the next clock edge.
        rstn = 1'b0;
        exp_rd("arst_pr", A_PR, 32'h0); exp_irq("arst_irq", 1'b0); sample();
        exp_rd("arst_cr", A_CR, 32'h0); sample();
        exp_rd("arst_mr", A_MR, 32'h0); sample();
        exp_rd("arst_tr", A_TR, 32'h0); sample();
        exp_rd("arst_vr", A_VR, 32'h0); sample();
        rstn = 1'b1;
        tick();

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sbq_drain: got %0d entries left expected 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
